// File: rtl/arb_mux_nb_if.sv
// Handshake bundle between CH producers, the arbitrating mux and one consumer.
// master = the mux itself, slave = the surrounding producers/consumer.
interface arb_mux_nb_if #(
    parameter int n  = 8,
    parameter int CH = 4
);
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH*n-1:0] D_IN;
    logic [CH-1:0]   VALID_IN;
    logic [CH-1:0]   READY_OUT;
    logic [1:0]      MODE;
    logic [3:0]      SEL;
    logic [n-1:0]    D_OUT;
    logic [SELW-1:0] SEL_OUT;
    logic            VALID_OUT;
    logic            READY_IN;

    modport master (
        input  D_IN, VALID_IN, MODE, SEL, READY_IN,
        output READY_OUT, D_OUT, SEL_OUT, VALID_OUT
    );

    modport slave (
        output D_IN, VALID_IN, MODE, SEL, READY_IN,
        input  READY_OUT, D_OUT, SEL_OUT, VALID_OUT
    );
endinterface

// File: rtl/arb_mux_nb.sv
// Registered CH-to-1 mux with valid/ready handshake and fixed-priority,
// round-robin or forced-select arbitration into a single output slot.
module arb_mux_nb #(
    parameter int n  = 8,
    parameter int CH = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    arb_mux_nb_if.master bus
);
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          r_state;
    logic [n-1:0]    r_dout;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_ptr;

    logic            w_found;
    logic [SELW-1:0] w_win;
    logic [SELW-1:0] w_ptr_nxt;
    logic [n-1:0]    w_data;
    logic            w_can_load;
    logic            w_accept;
    logic [CH-1:0]   w_ready;
    int              w_idx;

    // Winner search; the round-robin walk starts at r_ptr and wraps at CH.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        case (bus.MODE)
            2'd1: begin
                for (int k = 0; k < CH; k++) begin
                    w_idx = int'(r_ptr) + k;
                    if (w_idx >= CH) w_idx = w_idx - CH;
                    if (!w_found && bus.VALID_IN[w_idx]) begin
                        w_found = 1'b1;
                        w_win   = SELW'(w_idx);
                    end
                end
            end
            2'd2: begin
                // SEL outside 0..CH-1 never matches, leaving the eligible set empty.
                for (int i = 0; i < CH; i++) begin
                    if (bus.SEL == 4'(i) && bus.VALID_IN[i]) begin
                        w_found = 1'b1;
                        w_win   = SELW'(i);
                    end
                end
            end
            default: begin
                for (int i = CH - 1; i >= 0; i--) begin
                    if (bus.VALID_IN[i]) begin
                        w_found = 1'b1;
                        w_win   = SELW'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_win == SELW'(i)) w_data = bus.D_IN[i*n +: n];
        end
    end

    assign w_ptr_nxt  = (int'(w_win) == CH - 1) ? '0 : w_win + 1'b1;
    assign w_can_load = (r_state == EMPTY) || bus.READY_IN;
    // Gated by RST_N so no producer sees an accept while reset is held.
    assign w_accept   = RST_N && w_found && w_can_load;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < CH; i++) begin
            w_ready[i] = w_accept && (w_win == SELW'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= EMPTY;
            r_dout  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= FULL;
                        r_dout  <= w_data;
                        r_sel   <= w_win;
                        if (bus.MODE == 2'd1) r_ptr <= w_ptr_nxt;
                    end
                end
                FULL: begin
                    // Accept and drain share the edge, so a new word replaces the old one.
                    if (w_accept) begin
                        r_dout <= w_data;
                        r_sel  <= w_win;
                        if (bus.MODE == 2'd1) r_ptr <= w_ptr_nxt;
                    end else if (bus.READY_IN) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign bus.READY_OUT = w_ready;
    assign bus.D_OUT     = r_dout;
    assign bus.SEL_OUT   = r_sel;
    assign bus.VALID_OUT = (r_state == FULL);
endmodule

// File: tb/tb_arb_mux_nb.sv
// Directed plus random bench for arb_mux_nb against a transaction-level model
// of the arbitration rules (eligible set, winner, one-slot output buffer).
module tb_arb_mux_nb;
    localparam int N  = 8;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arb_mux_nb_if #(.n(N), .CH(CH)) bus();
    arb_mux_nb #(.n(N), .CH(CH)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    logic [N-1:0] din [CH];
    for (genvar g = 0; g < CH; g++) begin : g_din
        assign bus.D_IN[g*N +: N] = din[g];
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: one output slot plus the round-robin pointer.
    logic         m_vld;
    logic [N-1:0] m_dout;
    int           m_sel;
    int           m_ptr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_win(int mode, int sel, logic [CH-1:0] v, int ptr);
        if (mode == 2) return (sel < CH && v[sel]) ? sel : -1;
        if (mode == 1) begin
            for (int k = 0; k < CH; k++)
                if (v[(ptr + k) % CH]) return (ptr + k) % CH;
            return -1;
        end
        for (int c = 0; c < CH; c++)
            if (v[c]) return c;
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_dout = '0; m_sel = 0; m_ptr = 0;
    endtask

    // One cycle: drive at the falling edge, check READY_OUT before the rising
    // edge, advance the model at the edge, check the registered outputs after.
    task automatic step(int mode, int sel, logic [CH-1:0] v, logic rdy);
        int w;
        logic ld;
        logic [CH-1:0] exp_ro;
        bus.MODE = 2'(mode); bus.SEL = 4'(sel); bus.VALID_IN = v; bus.READY_IN = rdy;
        #1;
        w      = model_win(mode, sel, v, m_ptr);
        ld     = (w >= 0) && (!m_vld || rdy);
        exp_ro = ld ? (CH'(1) << w) : '0;
        chk("ready_out", 32'(bus.READY_OUT), 32'(exp_ro));
        @(posedge clk);
        if (ld) begin
            m_dout = din[w]; m_sel = w; m_vld = 1'b1;
            if (mode == 1) m_ptr = (w + 1) % CH;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        #1;
        chk("valid_out", 32'(bus.VALID_OUT), 32'(m_vld));
        chk("d_out",     32'(bus.D_OUT),     32'(m_dout));
        chk("sel_out",   32'(bus.SEL_OUT),   32'(m_sel));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.MODE = 2'd0; bus.SEL = 4'd0; bus.VALID_IN = '0; bus.READY_IN = 1'b0;
        for (int i = 0; i < CH; i++) din[i] = 8'hA0 + 8'(i);
        model_reset();
        #1;
        chk("rst_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("rst_dout",  32'(bus.D_OUT),     32'd0);
        chk("rst_sel",   32'(bus.SEL_OUT),   32'd0);
        bus.VALID_IN = '1;
        #1;
        chk("rst_ready", 32'(bus.READY_OUT), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 4'b1111, 1'b1);
            chk("rr_dout", 32'(bus.D_OUT),   32'(8'hA0 + 8'(i % 4)));
            chk("rr_sel",  32'(bus.SEL_OUT), 32'(i % 4));
        end

        // Fixed priority
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'b1010, 1'b1);
            chk("fp_sel", 32'(bus.SEL_OUT), 32'd1);
        end
        step(0, 0, 4'b1000, 1'b1);
        chk("fp_ch3", 32'(bus.D_OUT), 32'hA3);

        // Backpressure
        din[0] = 8'h55;
        step(0, 0, 4'b0001, 1'b1);
        din[0] = 8'h66;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'b1111, 1'b0);
            chk("bp_hold", 32'(bus.D_OUT), 32'h55);
        end
        step(0, 0, 4'b1111, 1'b1);
        chk("bp_release", 32'(bus.D_OUT), 32'h66);
        din[0] = 8'hA0;

        // Forced select, then out-of-range SEL drains the slot
        for (int i = 0; i < 3; i++) begin
            step(2, 2, 4'b1111, 1'b1);
            chk("fs_dout", 32'(bus.D_OUT), 32'hA2);
        end
        step(2, 5, 4'b1111, 1'b1);
        chk("fs_drain", 32'(bus.VALID_OUT), 32'd0);
        step(2, 5, 4'b1111, 1'b1);

        // Wrap-around: grant channel 2 to park the pointer at 3
        step(1, 0, 4'b0100, 1'b1);
        step(1, 0, 4'b1001, 1'b1);
        chk("wrap_first", 32'(bus.SEL_OUT), 32'd3);
        step(1, 0, 4'b1001, 1'b1);
        chk("wrap_second", 32'(bus.SEL_OUT), 32'd0);
        step(1, 0, 4'b1111, 1'b1);
        chk("wrap_ptr1", 32'(bus.SEL_OUT), 32'd1);

        // Asynchronous reset while FULL and stalled
        step(0, 0, 4'b0001, 1'b0);
        bus.VALID_IN = 4'b1111; bus.READY_IN = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("arst_dout",  32'(bus.D_OUT),     32'd0);
        chk("arst_sel",   32'(bus.SEL_OUT),   32'd0);
        chk("arst_ready", 32'(bus.READY_OUT), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 4'b0110, 1'b1);
        chk("arst_ptr0", 32'(bus.SEL_OUT), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) din[c] = 8'($urandom);
            step(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_mux_nb.md
# arb_mux_nb

Registered, parametrised n-bit CH-to-1 multiplexer with valid/ready handshaking and selectable arbitration. It succeeds the combinational 4-to-1 data mux and is used in the RAT datapath wherever several producers share one consumer, such as interrupt/IO sources feeding a shared bus. It supports fixed-priority, round-robin, and forced-select modes. The forced-select mode preserves the legacy SEL-driven behaviour.

## Interface

Parameters:
- n, 8, data width per channel (≥1)
- CH, 4, channel count (2..16)
- SELW, $clog2(CH), width of channel index (derived; not overridden)

Ports:
- CLK  input  1  system clock, rising-edge active
- RST_N  input  1  reset, asynchronous, active-low
- D_IN  input  CH*n  flattened channel data; channel i at D_IN[i*n +: n]
- VALID_IN  input  CH  per-channel request
- READY_OUT  output  CH  per-channel accept strobe; at most one bit high
- MODE  input  2  0 = fixed priority, 1 = round-robin, 2 = forced select, 3 = reserved (behaves as 0)
- SEL  input  4  forced-select channel index (MODE=2 only)
- D_OUT  output  n  registered output data
- SEL_OUT  output  SELW  channel index that produced D_OUT
- VALID_OUT  output  1  D_OUT holds an unconsumed word
- READY_IN  input  1  consumer accepts D_OUT this cycle

## Operation

- **States.** The block has two states:
  - EMPTY: VALID_OUT=0.
  - FULL: VALID_OUT=1.
- **Load condition.** can_load = !VALID_OUT || READY_IN.
- **Eligible set.** The eligible set depends on MODE:
  - MODE 0/3: all VALID_IN bits.
  - MODE 1: all VALID_IN bits.
  - MODE 2: only VALID_IN[SEL], and only if SEL < CH. If SEL ≥ CH the eligible set is empty, matching the legacy "output 0" case.
- **Winner selection.**
  - MODE 0/3: the lowest eligible index wins.
  - MODE 1: search starts at rotating pointer ptr, runs ptr, ptr+1, …, CH-1, 0, …, ptr-1, and takes the first eligible index.
  - MODE 2: SEL wins.
- **READY_OUT.** READY_OUT[w]=1 combinationally only when can_load and a winner w exists. All other bits are 0.
- **Accept edge.** On an edge where READY_OUT[w]=1:
  - D_OUT ← D_IN[w*n +: n]
  - SEL_OUT ← w
  - VALID_OUT ← 1
  - In MODE 1 only: ptr ← (w+1) mod CH, wrapping from CH-1 to 0.
- **Drain edge.** On an edge with VALID_OUT && READY_IN and no winner: VALID_OUT ← 0. D_OUT and SEL_OUT retain their last values.
- **Hold.** While VALID_OUT && !READY_IN:
  - D_OUT and SEL_OUT are stable.
  - All READY_OUT bits are 0.
- **Pointer retention.** ptr is retained across MODE changes and is never modified in MODE 0/2/3.
- **Mode changes.** MODE and SEL are sampled every cycle. Changing them while FULL does not alter the held word.
- **Reset.** RST_N low clears, asynchronously:
  - D_OUT = 0
  - SEL_OUT = 0
  - VALID_OUT = 0
  - ptr = 0
  
  READY_OUT is 0 while RST_N is low. A word held when reset asserts is discarded.

## Timing

- Latency: accept edge → VALID_OUT high is 1 cycle.
- Throughput: one word per cycle while READY_IN=1 and any channel is eligible. Back-to-back accept plus drain on the same edge is required.
- READY_OUT is combinational from VALID_IN, MODE, SEL, READY_IN, VALID_OUT and ptr. There are no register stages on this path; the consumer must not make READY_IN depend on READY_OUT.
- A producer transfers on an edge where its VALID_IN=1 and READY_OUT=1. A producer may deassert VALID_IN at any time without penalty.
- RST_N deassertion is synchronised externally. The first accept may occur on the first edge after release.

## Test plan

- **Reset.**
  - Stimulus: in FULL with READY_IN=0, pull RST_N low mid-cycle.
  - Required response: VALID_OUT, D_OUT and SEL_OUT go to 0 immediately, without waiting for a clock edge. After release, ptr=0, confirmed by the first MODE 1 winner being the lowest valid channel at or after index 0.
- **Round-robin fairness.**
  - Stimulus: CH=4, n=8, MODE=1, VALID_IN=4'b1111, D_IN channel i = 8'hA0+i, READY_IN=1.
  - Required response: D_OUT sequence A0, A1, A2, A3, A0 on consecutive cycles; SEL_OUT 0, 1, 2, 3, 0.
- **Fixed priority.**
  - Stimulus: MODE=0, VALID_IN=4'b1010.
  - Required response: channel 1 wins every cycle and channel 3 receives no READY_OUT. Clearing VALID_IN[1] makes D_OUT equal channel 3 data on the next edge.
- **Backpressure.**
  - Stimulus: word 8'h55 held, READY_IN=0 for 5 cycles.
  - Required response: D_OUT=55 stable and READY_OUT=0 throughout. In the cycle READY_IN rises, READY_OUT of the next winner rises in the same cycle, and D_OUT updates on that edge.
- **Forced select.**
  - Stimulus: MODE=2, SEL=2, VALID_IN=4'b1111.
  - Required response: only READY_OUT[2] is ever asserted. Changing to SEL=5 yields READY_OUT=0, and VALID_OUT drops one edge after READY_IN.
- **Wrap-around.**
  - Stimulus: MODE=1, ptr=3 (reached via prior grants), VALID_IN=4'b1001.
  - Required response: channel 3 wins first, then channel 0, with ptr wrapping 0→1.
